simon_game_fsm: RTL and testbench

SIMON_GAME_FSM -- requirements
Module: simon_game_fsm

---
 rtl/simon_game_fsm_if.sv | 36 +++
 rtl/simon_game_fsm.sv | 239 +++++++++++++++++++++++
 tb/tb_simon_game_fsm.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_game_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : simon_game_fsm_if
//  Description : Signal bundle between the Simon game controller and its
//                environment (start/button inputs, shared random-number bus,
//                display and status outputs).
//  Ports       : none (signal container)
//                start, btn[3:0], bus_in[7:0]          -> controller
//                bus_oe, led[3:0], score[7:0],
//                busy, game_over, win                  <- controller
//  Modports    : master - environment side (drives start/btn/bus_in)
//                slave  - controller side (drives display/status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface simon_game_fsm_if;
  logic       start;
  logic [3:0] btn;
  logic [7:0] bus_in;
  logic       bus_oe;
  logic [3:0] led;
  logic [7:0] score;
  logic       busy;
  logic       game_over;
  logic       win;

  modport master (
    output start, btn, bus_in,
    input  bus_oe, led, score, busy, game_over, win
  );

  modport slave (
    input  start, btn, bus_in,
    output bus_oe, led, score, busy, game_over, win
  );
endinterface
`default_nettype wire

// File: rtl/simon_game_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : simon_game_fsm
//  Description : Simon memory game controller. Each round appends one random
//                colour (sampled from a shared bus during a one-cycle GEN
//                state), replays the whole sequence on the LEDs, then checks
//                the player's button presses against it.
//  Parameters  : MAX_LEN        - rounds needed to win (1..16)
//                TONE_CYCLES    - cycles each colour is lit
//                GAP_CYCLES     - dark cycles after each colour
//                TIMEOUT_CYCLES - player inactivity limit (timeout build only)
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                sif   - simon_game_fsm_if.slave:
//                        start, btn[3:0], bus_in[7:0] (in)
//                        bus_oe, led[3:0], score[7:0], busy, game_over, win
//  Options     : define SIMON_TIMEOUT_EN to lose after TIMEOUT_CYCLES
//                consecutive cycles without a press while awaiting input.
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_game_fsm #(
  parameter int MAX_LEN        = 16,
  parameter int TONE_CYCLES    = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  simon_game_fsm_if.slave  sif
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = 16;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GEN      = 3'd1;
  localparam logic [2:0] S_SHOW_ON  = 3'd2;
  localparam logic [2:0] S_SHOW_OFF = 3'd3;
  localparam logic [2:0] S_WAIT_IN  = 3'd4;
  localparam logic [2:0] S_WIN      = 3'd5;
  localparam logic [2:0] S_LOSE     = 3'd6;

  function automatic logic [3:0] f_onehot(input logic [1:0] col);
    f_onehot = 4'b0001 << col;
  endfunction

  logic [2:0]       r_state;
  logic [1:0]       r_seq [MAX_LEN];
  logic [LEN_W-1:0] r_len;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_btn_prev;
  logic             r_bus_oe;
  logic [3:0]       r_led;
  logic [7:0]       r_score;
  logic             r_busy;
  logic             r_game_over;
  logic             r_win;

  logic [2:0]       w_state_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       w_score_nxt;
  logic             w_seq_we;
  logic [3:0]       w_edge;
  logic [3:0]       w_exp_oh;
  logic             w_last;
  logic [1:0]       w_show_col;
  logic [3:0]       w_led_nxt;
  logic             w_unused;

`ifdef SIMON_TIMEOUT_EN
  logic [CNT_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] w_to_nxt;
`endif

  // Upper bus bits carry nothing the game needs.
  assign w_unused = ^{sif.bus_in[7:2], 1'(TIMEOUT_CYCLES)};

  assign w_edge   = sif.btn & ~r_btn_prev;
  assign w_exp_oh = f_onehot(r_seq[r_idx]);
  // Current index is the final element of the stored sequence.
  assign w_last   = (LEN_W'(r_idx) + LEN_W'(1)) >= r_len;

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_score_nxt = r_score;
    w_seq_we    = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    w_to_nxt    = r_to_cnt;
`endif
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (sif.start) begin
          w_state_nxt = S_GEN;
          w_len_nxt   = '0;
          w_score_nxt = '0;
        end
      end
      S_GEN: begin
        w_seq_we    = 1'b1;
        w_len_nxt   = r_len + LEN_W'(1);
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (r_cnt == CNT_W'(TONE_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHOW_OFF;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SHOW_OFF: begin
        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          w_cnt_nxt = '0;
          if (!w_last) begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_SHOW_ON;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = S_WAIT_IN;
`ifdef SIMON_TIMEOUT_EN
            w_to_nxt    = '0;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_IN: begin
        if (w_edge != 4'b0000) begin
`ifdef SIMON_TIMEOUT_EN
          w_to_nxt = '0;
`endif
          // A multi-bit edge can never equal a one-hot colour, so it loses.
          if (w_edge == w_exp_oh) begin
            if (!w_last) begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end else begin
              w_score_nxt = 8'(r_len);
              w_state_nxt = (r_len == LEN_W'(MAX_LEN)) ? S_WIN : S_GEN;
            end
          end else begin
            w_state_nxt = S_LOSE;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = S_LOSE;
        end else begin
          w_to_nxt = r_to_cnt + CNT_W'(1);
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Colour shown next cycle; the GEN write is bypassed so the new element
  // is visible on the very first SHOW_ON cycle.
  always_comb begin
    w_show_col = r_seq[w_idx_nxt];
    if (w_seq_we && (IDX_W'(r_len) == w_idx_nxt)) begin
      w_show_col = sif.bus_in[1:0];
    end
    case (w_state_nxt)
      S_SHOW_ON, S_LOSE: w_led_nxt = f_onehot(w_show_col);
      S_WIN:             w_led_nxt = 4'b1111;
      default:           w_led_nxt = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seq[i] <= '0;
      end
    end else if (w_seq_we) begin
      r_seq[IDX_W'(r_len)] <= sif.bus_in[1:0];
    end
  end

  // Outputs are registered from the next-state view so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_btn_prev  <= '0;
      r_bus_oe    <= 1'b0;
      r_led       <= '0;
      r_score     <= '0;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
      r_win       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      // Edge history restarts on entry to input collection.
      r_btn_prev  <= (w_state_nxt == S_WAIT_IN && r_state != S_WAIT_IN) ? 4'b0000 : sif.btn;
      r_bus_oe    <= (w_state_nxt == S_GEN);
      r_led       <= w_led_nxt;
      r_score     <= w_score_nxt;
      r_busy      <= !(w_state_nxt == S_IDLE || w_state_nxt == S_WIN || w_state_nxt == S_LOSE);
      r_game_over <= (w_state_nxt == S_LOSE);
      r_win       <= (w_state_nxt == S_WIN);
    end
  end

`ifdef SIMON_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_nxt;
    end
  end
`endif

  assign sif.bus_oe    = r_bus_oe;
  assign sif.led       = r_led;
  assign sif.score     = r_score;
  assign sif.busy      = r_busy;
  assign sif.game_over = r_game_over;
  assign sif.win       = r_win;

endmodule
`default_nettype wire

// File: tb/tb_simon_game_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simon_game_fsm
//  Description : Self-checking bench for simon_game_fsm. Two instances share
//                stimulus: dut0 with MAX_LEN=16, dut1 with MAX_LEN=2 and
//                TIMEOUT_CYCLES=10. A queue-based game model predicts every
//                checked output vector.
//  Options     : honours SIMON_TIMEOUT_EN for the inactivity scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_game_fsm;
  localparam int TONE = 8;
  localparam int GAP  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] btn;
  logic [7:0] bus_in;
  logic       sel;
  logic [15:0] obs;

  int total;
  int bad;
  int mseq[$];
  int mscore;
  int midx;
  int mmax;
  bit ended;

  always #5 clk = ~clk;

  simon_game_fsm_if if0 ();
  simon_game_fsm_if if1 ();

  assign if0.start  = start & ~sel;
  assign if1.start  = start & sel;
  assign if0.btn    = btn;
  assign if1.btn    = btn;
  assign if0.bus_in = bus_in;
  assign if1.bus_in = bus_in;

  simon_game_fsm u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (if0.slave)
  );

  simon_game_fsm #(.MAX_LEN(2), .TIMEOUT_CYCLES(10)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (if1.slave)
  );

  assign obs = sel ? {if1.bus_oe, if1.led, if1.score, if1.busy, if1.game_over, if1.win}
                   : {if0.bus_oe, if0.led, if0.score, if0.busy, if0.game_over, if0.win};

  function automatic logic [3:0] oh(input int c);
    oh = 4'b0001 << c;
  endfunction

  // {bus_oe, led, score, busy, game_over, win}
  function automatic logic [15:0] pk(bit oe, logic [3:0] l, int sc, bit bz, bit go, bit w);
    pk = {oe, l, 8'(sc), bz, go, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%04h expected=%04h (oe,led,score,busy,go,win)", tag, obs, e);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    mseq.delete();
    mscore = 0;
    expect_out("start_gen", pk(1, 4'h0, 0, 1, 0, 0));
  endtask

  // Leaves GEN with the given bus byte and checks the full replay.
  task automatic gen_show(input logic [7:0] b);
    bus_in = b;
    mseq.push_back(int'(b[1:0]));
    tick();
    bus_in = 8'($urandom);
    foreach (mseq[k]) begin
      repeat (TONE) begin
        expect_out("show_on", pk(0, oh(mseq[k]), mscore, 1, 0, 0));
        tick();
      end
      repeat (GAP) begin
        expect_out("show_off", pk(0, 4'h0, mscore, 1, 0, 0));
        tick();
      end
    end
    midx = 0;
    expect_out("wait_in", pk(0, 4'h0, mscore, 1, 0, 0));
  endtask

  task automatic press(input logic [3:0] b, output bit fin);
    int col;
    col = mseq[midx];
    btn = b;
    tick();
    btn = 4'h0;
    fin = 1'b0;
    if (b != oh(col)) begin
      expect_out("press_lose", pk(0, oh(col), mscore, 0, 1, 0));
      fin = 1'b1;
    end else if (midx < mseq.size() - 1) begin
      midx++;
      expect_out("press_ok", pk(0, 4'h0, mscore, 1, 0, 0));
      tick();
      expect_out("press_release", pk(0, 4'h0, mscore, 1, 0, 0));
    end else begin
      mscore = mseq.size();
      if (mseq.size() == mmax) begin
        expect_out("press_win", pk(0, 4'hF, mscore, 0, 0, 1));
        fin = 1'b1;
      end else begin
        expect_out("press_round", pk(1, 4'h0, mscore, 1, 0, 0));
      end
    end
  endtask

  initial begin
    logic [3:0] b;
    bit done;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    btn   = 4'h0;
    bus_in = 8'h00;
    sel   = 1'b0;
    mmax  = 16;
    mscore = 0;
    midx  = 0;

    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_dut0", 16'h0000);
    sel = 1'b1;
    expect_out("reset_dut1", 16'h0000);
    sel = 1'b0;
    rst_n = 1'b1;
    tick();
    expect_out("idle_after_reset", 16'h0000);

    // Wrong colour at the second position of {2,1}.
    do_start();
    gen_show(8'h06);
    press(4'b0100, ended);
    gen_show(8'h01);
    press(4'b0100, ended);
    press(4'b0001, ended);
    tick();
    expect_out("lose_holds", pk(0, 4'b0010, 1, 0, 1, 0));

    // Restart from LOSE, then two correct rounds.
    do_start();
    gen_show(8'h06);
    press(4'b0100, ended);
    gen_show(8'h01);
    press(4'b0100, ended);
    press(4'b0010, ended);

    // Asynchronous reset while the third round is being shown.
    bus_in = 8'($urandom);
    mseq.push_back(int'(bus_in[1:0]));
    tick();
    expect_out("len3_show", pk(0, oh(mseq[0]), 2, 1, 0, 0));
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 expect_out("reset_async", 16'h0000);
    tick();
    expect_out("reset_held", 16'h0000);
    rst_n = 1'b1;
    tick();
    expect_out("idle_after_release", 16'h0000);

    // Randomized games with occasional wrong presses.
    for (int g = 0; g < 3; g++) begin
      do_start();
      done = 1'b0;
      while (!done) begin
        gen_show(8'($urandom));
        for (int k = 0; k < mseq.size() && !done; k++) begin
          repeat ($urandom_range(0, 2)) begin
            tick();
            expect_out("rand_wait", pk(0, 4'h0, mscore, 1, 0, 0));
          end
          if ($urandom_range(0, 29) == 0) begin
            do b = 4'($urandom_range(1, 15)); while (b == oh(mseq[midx]));
          end else begin
            b = oh(mseq[midx]);
          end
          press(b, done);
        end
      end
    end

    // MAX_LEN=2 instance: win, then a two-button press, then inactivity.
    sel = 1'b1;
    mmax = 2;
    do_start();
    gen_show(8'($urandom));
    press(oh(mseq[0]), ended);
    gen_show(8'($urandom));
    press(oh(mseq[0]), ended);
    press(oh(mseq[1]), ended);
    tick();
    expect_out("win_holds", pk(0, 4'hF, 2, 0, 0, 1));

    do_start();
    gen_show(8'($urandom));
    press(4'b0011, ended);

    do_start();
    gen_show(8'($urandom));
`ifdef SIMON_TIMEOUT_EN
    repeat (9) begin
      tick();
      expect_out("timeout_pending", pk(0, 4'h0, 0, 1, 0, 0));
    end
    tick();
    expect_out("timeout_lose", pk(0, oh(mseq[0]), 0, 0, 1, 0));
`else
    repeat (1000) tick();
    expect_out("no_timeout", pk(0, 4'h0, 0, 1, 0, 0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
